// File: rtl/uart_custom_pkg.sv
// Shared definitions for the custom 8N1 UART.
// Holds the FSM state encodings used by both the RX and TX cores, the
// default bit period and the data width.
package uart_custom_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int DATA_BITS            = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver, LSB first, idle-high line.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   rx_serial_in asynchronous serial input
//   data_out     last correctly framed byte (holds between pulses)
//   byte_ready   one-cycle pulse when data_out is updated
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for a low level on the synchronised line
// ST_START | counting to mid start bit, then glitch check
// ST_DATA  | sampling 8 data bits at mid-bit
// ST_STOP  | sampling mid stop bit; load data_out if high
module uart_rx_core
  import uart_custom_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 byte_ready
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  // Down-counter reload values; terminal count is zero.
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic                 sync_1;
  logic                 sync_2;
  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser resets to the idle level so release does not look like a start bit.
      sync_1     <= 1'b1;
      sync_2     <= 1'b1;
      state      <= ST_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      byte_ready <= 1'b0;
    end else begin
      sync_1     <= rx_serial_in;
      sync_2     <= sync_1;
      byte_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sync_2) begin
            state <= ST_START;
            timer <= HALF_LAST;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            if (sync_2) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              timer   <= BIT_LAST;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            shift_reg[bit_idx] <= sync_2;
            timer              <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_STOP: begin
          if (timer == '0) begin
            // Returning to idle at mid stop bit lets back-to-back frames through.
            state <= ST_IDLE;
            if (sync_2) begin
              data_out   <= shift_reg;
              byte_ready <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 transmitter, LSB first, idle-high line.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   tx_start      request to send data_in (ignored while busy)
//   data_in       byte to send, latched on acceptance
//   tx_serial_out serial output
//   tx_busy       high for the 10 bit periods of a frame
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | line high, waiting for tx_start
// ST_START | driving the start bit (low)
// ST_DATA  | shifting out 8 data bits
// ST_STOP  | driving the stop bit (high)
module uart_tx_core
  import uart_custom_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_serial_out,
  output logic                 tx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  // Line and busy are registered so they change together on the bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      tx_serial_out <= 1'b1;
      tx_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_serial_out <= 1'b1;
          tx_busy       <= 1'b0;
          if (tx_start) begin
            shift_reg     <= data_in;
            state         <= ST_START;
            timer         <= BIT_LAST;
            tx_serial_out <= 1'b0;
            tx_busy       <= 1'b1;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            state         <= ST_DATA;
            timer         <= BIT_LAST;
            bit_idx       <= '0;
            tx_serial_out <= shift_reg[0];
            shift_reg     <= shift_reg >> 1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            timer <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state         <= ST_STOP;
              tx_serial_out <= 1'b1;
            end else begin
              bit_idx       <= bit_idx + 3'd1;
              tx_serial_out <= shift_reg[0];
              shift_reg     <= shift_reg >> 1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_STOP: begin
          if (timer == '0) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_tx_custom.sv
// Custom 8N1 UART: independent receiver and transmitter on one clock.
// Serial front end of the matrix-multiply top.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_serial_in                serial input (asynchronous, idle high)
//   data_out, byte_ready        received byte and its one-cycle strobe
//   tx_start, data_in           transmit request and byte
//   tx_serial_out, tx_busy      serial output and frame-in-progress flag
// CLKS_PER_BIT must be 4 or more.
module uart_rx_tx_custom
  import uart_custom_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 byte_ready,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_serial_out,
  output logic                 tx_busy
);

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_serial_in (rx_serial_in),
    .data_out     (data_out),
    .byte_ready   (byte_ready)
  );

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk           (clk),
    .rst           (rst),
    .tx_start      (tx_start),
    .data_in       (data_in),
    .tx_serial_out (tx_serial_out),
    .tx_busy       (tx_busy)
  );

endmodule

// File: tb/tb_uart_rx_tx_custom.sv
module tb_uart_rx_tx_custom;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_drive;
  logic       loop_en;
  logic       rx_line;
  logic [7:0] data_out;
  logic       byte_ready;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx_serial_out;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rx_cnt   = 0;
  int pulse_cyc = 0;
  logic [7:0] rx_log [0:31];

  assign rx_line = loop_en ? tx_serial_out : rx_drive;

  uart_rx_tx_custom #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial_in  (rx_line),
    .data_out      (data_out),
    .byte_ready    (byte_ready),
    .tx_start      (tx_start),
    .data_in       (data_in),
    .tx_serial_out (tx_serial_out),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_ready === 1'b1) begin
      if (rx_cnt < 32) rx_log[rx_cnt] = data_out;
      rx_cnt    = rx_cnt + 1;
      pulse_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drive = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_drive = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    rx_drive = 1'b1;
  endtask

  // Checks {tx_busy, tx_serial_out} at negedges for frame cycles first..79;
  // caller is positioned just after the edge preceding cycle 'first'.
  task automatic check_tx_frame(input string tag, input logic [7:0] b, input int first);
    logic [9:0] frame;
    int         errs;
    frame = {1'b1, b, 1'b0};
    errs  = 0;
    for (int c = first; c < 80; c++) begin
      @(negedge clk);
      if (tx_busy !== 1'b1 || tx_serial_out !== frame[c / CPB]) errs++;
    end
    chk(tag, errs, 0);
  endtask

  task automatic tx_send_b2b(input logic [7:0] b);
    int n;
    tx_start = 1'b1;
    data_in  = b;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy !== 1'b0 && n < 200);
    chk("tx_b2b_busy_end", {31'd0, tx_busy}, 0);
  endtask

  initial begin
    int base;
    int start_cyc;
    int hi_cnt;

    // 1. Reset with tx_start high and rx line low.
    rst      = 1'b1;
    tx_start = 1'b1;
    data_in  = 8'h5A;
    rx_drive = 1'b0;
    loop_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_line", {31'd0, tx_serial_out}, 1);
    chk("rst_tx_busy", {31'd0, tx_busy}, 0);
    chk("rst_byte_ready", {31'd0, byte_ready}, 0);
    chk("rst_data_out", {24'd0, data_out}, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_start = 1'b0;
    rx_drive = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_tx_busy", {31'd0, tx_busy}, 0);
    chk("post_rst_rx_cnt", rx_cnt, 0);

    // 2. RX single byte 0xA5.
    @(posedge clk);
    #1;
    base      = rx_cnt;
    start_cyc = cyc;
    send_rx(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    chk("rx_a5_pulses", rx_cnt - base, 1);
    chk("rx_a5_data", {24'd0, data_out}, 32'hA5);
    chk("rx_a5_log", {24'd0, rx_log[base]}, 32'hA5);
    chk("rx_a5_latency_ok", {31'd0, (pulse_cyc - start_cyc) <= 84 && pulse_cyc > start_cyc}, 1);

    // 3. Glitch, then framing error.
    @(posedge clk);
    #1;
    base     = rx_cnt;
    rx_drive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_drive = 1'b1;
    repeat (20) @(negedge clk);
    chk("rx_glitch_pulses", rx_cnt - base, 0);
    @(posedge clk);
    #1;
    send_rx(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_frame_err_pulses", rx_cnt - base, 0);
    chk("rx_frame_err_hold", {24'd0, data_out}, 32'hA5);

    // 4. TX single byte 0x96.
    @(posedge clk);
    #1;
    data_in  = 8'h96;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    data_in  = 8'h00;
    check_tx_frame("tx_96_frame", 8'h96, 0);
    @(negedge clk);
    chk("tx_96_busy_end", {31'd0, tx_busy}, 0);
    chk("tx_96_line_end", {31'd0, tx_serial_out}, 1);

    // 5. Repeated start, data change after acceptance, then back-to-back.
    @(posedge clk);
    #1;
    data_in  = 8'h11;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    data_in  = 8'hFF;
    check_tx_frame("tx_11_frame", 8'h11, 1);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    data_in  = 8'h22;
    @(negedge clk);
    chk("tx_gap_busy_low", {31'd0, tx_busy}, 0);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    data_in  = 8'hFF;
    check_tx_frame("tx_22_frame", 8'h22, 0);
    hi_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_serial_out !== 1'b1) hi_cnt++;
    end
    chk("tx_no_extra_frame", hi_cnt, 0);

    // 6. Loopback, four back-to-back frames.
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    base = rx_cnt;
    tx_send_b2b(8'h00);
    tx_send_b2b(8'hFF);
    tx_send_b2b(8'h5A);
    tx_send_b2b(8'h80);
    repeat (20) @(negedge clk);
    chk("loop_pulses", rx_cnt - base, 4);
    chk("loop_b0", {24'd0, rx_log[base]}, 32'h00);
    chk("loop_b1", {24'd0, rx_log[base + 1]}, 32'hFF);
    chk("loop_b2", {24'd0, rx_log[base + 2]}, 32'h5A);
    chk("loop_b3", {24'd0, rx_log[base + 3]}, 32'h80);
    chk("loop_data_out", {24'd0, data_out}, 32'h80);

    // Reset mid-frame aborts TX immediately.
    loop_en = 1'b0;
    @(posedge clk);
    #1;
    data_in  = 8'h00;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_busy", {31'd0, tx_busy}, 0);
    chk("midrst_tx_line", {31'd0, tx_serial_out}, 1);
    chk("midrst_data_out", {24'd0, data_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
